// File: rtl/sd_pkg.sv
// Shared SD SPI-mode definitions: arbiter states, bus owner
// and command indices used by the block engines.
package sd_pkg;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_t;

    localparam int DEF_TIMEOUT    = 4096;
    localparam int DEF_GAP_CYCLES = 8;

    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;

endpackage

// File: rtl/sd_watchdog.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
// Shared by the arbiter and the engines' response timeouts.
module sd_watchdog #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sd_access_arbiter.sv
// Round-robin owner of the SD SPI bus: init engine until the card is
// ready, then one read or write engine per transaction with idle gaps.
module sd_access_arbiter
    import sd_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              init_csn,
    input  logic              init_mosi,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_done,
    output logic              rd_err,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              wr_err,
    output logic [ADDR_W-1:0] blk_addr,
    output logic              rd_start,
    output logic              wr_start,
    output logic              eng_abort,
    input  logic              rd_eng_done,
    input  logic              rd_eng_err,
    input  logic              wr_eng_done,
    input  logic              wr_eng_err,
    input  logic              rd_eng_csn,
    input  logic              rd_eng_mosi,
    input  logic              wr_eng_csn,
    input  logic              wr_eng_mosi,
    output logic              SD_CSn,
    output logic              SD_MOSI
);

    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [2:0]       state;
    owner_t           owner;
    owner_t           last_grant;
    logic [GAP_W-1:0] gap_cnt;

    logic own_done;
    logic own_err;
    logic wd_expired;
    logic fin;
    logic fin_err;
    logic abort_c;
    logic pick_rd;
    logic pick_wr;

    sd_watchdog #(.W(WD_W)) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_START),
        .en       (state == ST_BUSY),
        .load_val (WD_W'(TIMEOUT - 1)),
        .expired  (wd_expired)
    );

    assign own_done = (owner == OWN_WR) ? wr_eng_done : rd_eng_done;
    assign own_err  = (owner == OWN_WR) ? wr_eng_err  : rd_eng_err;

    // Read wins a tie unless it was the last side served.
    assign pick_rd = rd_req && (!wr_req || (last_grant == OWN_WR));
    assign pick_wr = wr_req && !pick_rd;

    // Card re-init beats everything; engine done beats watchdog expiry.
    always_comb begin
        fin     = 1'b0;
        fin_err = 1'b0;
        abort_c = 1'b0;
        if ((state == ST_START) || (state == ST_BUSY)) begin
            if (!init_done) begin
                fin     = 1'b1;
                fin_err = 1'b1;
                abort_c = 1'b1;
            end else if (state == ST_BUSY) begin
                if (own_done) begin
                    fin     = 1'b1;
                    fin_err = own_err;
                end else if (wd_expired) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    abort_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            owner      <= OWN_RD;
            last_grant <= OWN_WR;
            gap_cnt    <= '0;
            blk_addr   <= '0;
            rd_gnt     <= 1'b0;
            wr_gnt     <= 1'b0;
            rd_start   <= 1'b0;
            wr_start   <= 1'b0;
            rd_done    <= 1'b0;
            wr_done    <= 1'b0;
            rd_err     <= 1'b0;
            wr_err     <= 1'b0;
            eng_abort  <= 1'b0;
        end else begin
            rd_gnt    <= 1'b0;
            wr_gnt    <= 1'b0;
            rd_start  <= 1'b0;
            wr_start  <= 1'b0;
            rd_done   <= fin && (owner == OWN_RD);
            wr_done   <= fin && (owner == OWN_WR);
            rd_err    <= fin && fin_err && (owner == OWN_RD);
            wr_err    <= fin && fin_err && (owner == OWN_WR);
            eng_abort <= abort_c;
            case (state)
                ST_INIT: begin
                    if (init_done) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (!init_done) begin
                        state <= ST_INIT;
                    end else if (pick_rd) begin
                        rd_gnt     <= 1'b1;
                        blk_addr   <= rd_addr;
                        owner      <= OWN_RD;
                        last_grant <= OWN_RD;
                        state      <= ST_START;
                    end else if (pick_wr) begin
                        wr_gnt     <= 1'b1;
                        blk_addr   <= wr_addr;
                        owner      <= OWN_WR;
                        last_grant <= OWN_WR;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (!init_done) begin
                        state <= ST_INIT;
                    end else begin
                        rd_start <= (owner == OWN_RD);
                        wr_start <= (owner == OWN_WR);
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!init_done) begin
                        state <= ST_INIT;
                    end else if (fin) begin
                        gap_cnt <= GAP_W'(GAP_CYCLES);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!init_done) begin
                        state <= ST_INIT;
                    end else if (gap_cnt == '0) begin
                        state <= ST_ARB;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        SD_CSn  = 1'b1;
        SD_MOSI = 1'b1;
        if (state == ST_INIT) begin
            SD_CSn  = init_csn;
            SD_MOSI = init_mosi;
        end else if (state == ST_BUSY) begin
            SD_CSn  = (owner == OWN_WR) ? wr_eng_csn  : rd_eng_csn;
            SD_MOSI = (owner == OWN_WR) ? wr_eng_mosi : rd_eng_mosi;
        end
    end

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Scenario bench for sd_access_arbiter; completions are checked
// against a queue of expected {is_wr, err} results.
module tb_sd_access_arbiter;

    localparam int AW  = 32;
    localparam int TO  = 64;
    localparam int GAP = 8;
    localparam int LAT = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_done, init_csn, init_mosi;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_gnt, rd_done, rd_err;
    logic          wr_gnt, wr_done, wr_err;
    logic [AW-1:0] blk_addr;
    logic          rd_start, wr_start, eng_abort;
    logic          rd_eng_done, rd_eng_err, wr_eng_done, wr_eng_err;
    logic          rd_eng_csn, rd_eng_mosi, wr_eng_csn, wr_eng_mosi;
    logic          SD_CSn, SD_MOSI;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    sd_access_arbiter #(
        .ADDR_W(AW), .TIMEOUT(TO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .init_done(init_done), .init_csn(init_csn), .init_mosi(init_mosi),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_done(rd_done), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_gnt(wr_gnt), .wr_done(wr_done), .wr_err(wr_err),
        .blk_addr(blk_addr), .rd_start(rd_start), .wr_start(wr_start),
        .eng_abort(eng_abort),
        .rd_eng_done(rd_eng_done), .rd_eng_err(rd_eng_err),
        .wr_eng_done(wr_eng_done), .wr_eng_err(wr_eng_err),
        .rd_eng_csn(rd_eng_csn), .rd_eng_mosi(rd_eng_mosi),
        .wr_eng_csn(wr_eng_csn), .wr_eng_mosi(wr_eng_mosi),
        .SD_CSn(SD_CSn), .SD_MOSI(SD_MOSI)
    );

    task automatic idle_inputs();
        init_done = 0; init_csn = 1; init_mosi = 1;
        rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0;
        rd_eng_done = 0; rd_eng_err = 0; wr_eng_done = 0; wr_eng_err = 0;
        rd_eng_csn = 1; rd_eng_mosi = 1; wr_eng_csn = 1; wr_eng_mosi = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic wait_gnt(input int max, output bit seen,
                            output bit is_wr, output int cyc);
        seen = 0; is_wr = 0; cyc = 0;
        while (!seen && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (rd_gnt || wr_gnt) begin
                seen = 1; is_wr = wr_gnt;
            end
        end
    endtask

    task automatic wait_start(input int max, output bit seen,
                              output bit is_wr, output int cyc);
        seen = 0; is_wr = 0; cyc = 0;
        while (!seen && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (rd_start || wr_start) begin
                seen = 1; is_wr = wr_start;
            end
        end
    endtask

    task automatic wait_done(input int max, output bit seen, output bit is_wr,
                             output bit err, output bit abrt, output int cyc);
        seen = 0; is_wr = 0; err = 0; abrt = 0; cyc = 0;
        while (!seen && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (rd_done || wr_done) begin
                seen = 1; is_wr = wr_done;
                err = wr_done ? wr_err : rd_err;
                abrt = eng_abort;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rd_gnt, wr_gnt, rd_done, wr_done, rd_err, wr_err,
             rd_start, wr_start, eng_abort} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 0",
                     {rd_gnt, wr_gnt, rd_done, wr_done, rd_err, wr_err,
                      rd_start, wr_start, eng_abort});
        end
        n_checks++;
        if (blk_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_blk_addr: got %h want 0", blk_addr);
        end
        n_checks++;
        if ({SD_CSn, SD_MOSI} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_bus: got %b want 11", {SD_CSn, SD_MOSI});
        end
        rst_n = 1;
        @(negedge clk);
        init_csn = 0; init_mosi = 0;
        #1;
        n_checks++;
        if ({SD_CSn, SD_MOSI} !== 2'b00) begin
            n_fail++;
            $display("FAIL init_bus_mux: got %b want 00", {SD_CSn, SD_MOSI});
        end
        init_csn = 1; init_mosi = 1;
        exp_q.delete();
    endtask

    task automatic test_init_gate();
        bit seen, is_wr, err, abrt;
        int cyc;
        logic [1:0] e;
        rd_addr = 32'h0000_0010; rd_req = 1;
        wait_gnt(10, seen, is_wr, cyc);
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL gate_no_gnt: got gnt at %0d want none", cyc);
        end
        init_done = 1;
        wait_gnt(6, seen, is_wr, cyc);
        n_checks++;
        if ({seen, is_wr, cyc} !== {1'b1, 1'b0, 32'd2}) begin
            n_fail++;
            $display("FAIL gate_gnt: seen=%0b wr=%0b cyc=%0d want 1 0 2",
                     seen, is_wr, cyc);
        end
        rd_req = 0; rd_addr = 32'hDEAD_BEEF;
        wait_start(3, seen, is_wr, cyc);
        n_checks++;
        if ({seen, is_wr, cyc} !== {1'b1, 1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL gate_start: seen=%0b wr=%0b cyc=%0d want 1 0 1",
                     seen, is_wr, cyc);
        end
        n_checks++;
        if (blk_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL gate_blk_addr: got %h want 10", blk_addr);
        end
        rd_eng_csn = 0; rd_eng_mosi = 1;
        #1;
        n_checks++;
        if ({SD_CSn, SD_MOSI} !== 2'b01) begin
            n_fail++;
            $display("FAIL gate_bus_a: got %b want 01", {SD_CSn, SD_MOSI});
        end
        rd_eng_mosi = 0;
        #1;
        n_checks++;
        if ({SD_CSn, SD_MOSI} !== 2'b00) begin
            n_fail++;
            $display("FAIL gate_bus_b: got %b want 00", {SD_CSn, SD_MOSI});
        end
        @(negedge clk);
        exp_q.push_back(2'b00);
        rd_eng_done = 1;
        wait_done(5, seen, is_wr, err, abrt, cyc);
        rd_eng_done = 0; rd_eng_csn = 1; rd_eng_mosi = 1;
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL gate_done: seen=%0b queued=%0d", seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({is_wr, err} !== e) begin
                n_fail++;
                $display("FAIL gate_done: got %b want %b", {is_wr, err}, e);
            end
        end
    endtask

    task automatic test_round_robin();
        bit order[$];
        int ndone = 0, eng_cnt = 0, idle = 0, cyc = 0;
        bit eng_wr = 0, in_gap = 0;
        logic [1:0] e;
        do_reset();
        init_done = 1; rd_addr = 32'd100; wr_addr = 32'd200;
        rd_req = 1; wr_req = 1;
        while (ndone < 4 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            rd_eng_done = 0; wr_eng_done = 0;
            if (rd_gnt || wr_gnt) begin
                order.push_back(wr_gnt);
                if (order.size() == 4) begin
                    rd_req = 0; wr_req = 0;
                end
            end
            if (rd_done || wr_done) begin
                ndone++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_done: unexpected done wr=%0b", wr_done);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_done, wr_done ? wr_err : rd_err} !== e) begin
                        n_fail++;
                        $display("FAIL rr_done: got %b want %b",
                                 {wr_done, wr_done ? wr_err : rd_err}, e);
                    end
                end
                in_gap = 1; idle = 0;
            end else if (rd_start || wr_start) begin
                if (in_gap) begin
                    n_checks++;
                    if (idle < GAP) begin
                        n_fail++;
                        $display("FAIL rr_gap: got %0d idle want >= %0d",
                                 idle, GAP);
                    end
                end
                in_gap = 0;
                eng_wr = wr_start; eng_cnt = LAT;
                if (eng_wr) wr_eng_csn = 0; else rd_eng_csn = 0;
            end else if (in_gap && SD_CSn && SD_MOSI) begin
                idle++;
            end
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    exp_q.push_back({eng_wr, 1'b0});
                    if (eng_wr) begin
                        wr_eng_done = 1; wr_eng_csn = 1;
                    end else begin
                        rd_eng_done = 1; rd_eng_csn = 1;
                    end
                end
            end
        end
        rd_eng_done = 0; wr_eng_done = 0;
        n_checks++;
        if (ndone != 4 || order.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d dones %0d grants want 4 4",
                     ndone, order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] !== i[0]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got wr=%0b want wr=%0b",
                             i, order[i], i[0]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit seen, is_wr, err, abrt;
        int cyc;
        logic [1:0] e;
        do_reset();
        init_done = 1; wr_addr = 32'h0000_0ABC; wr_req = 1;
        wait_gnt(5, seen, is_wr, cyc);
        n_checks++;
        if ({seen, is_wr} !== 2'b11) begin
            n_fail++;
            $display("FAIL to_gnt: seen=%0b wr=%0b want 1 1", seen, is_wr);
        end
        wr_req = 0;
        wait_start(3, seen, is_wr, cyc);
        wr_eng_csn = 0;
        exp_q.push_back(2'b11);
        seen = 0; cyc = 0;
        while (!seen && cyc < 100) begin
            rd_eng_done = (cyc == 10);
            @(negedge clk);
            cyc++;
            if (rd_done || wr_done) begin
                seen = 1; is_wr = wr_done;
                err = wr_done ? wr_err : rd_err;
                abrt = eng_abort;
            end
        end
        rd_eng_done = 0;
        n_checks++;
        if ({seen, abrt, cyc} !== {1'b1, 1'b1, 32'd64}) begin
            n_fail++;
            $display("FAIL to_abort: seen=%0b abort=%0b cyc=%0d want 1 1 64",
                     seen, abrt, cyc);
        end
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL to_done: seen=%0b queued=%0d", seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({is_wr, err} !== e) begin
                n_fail++;
                $display("FAIL to_done: got %b want %b", {is_wr, err}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({SD_CSn, SD_MOSI, eng_abort, wr_done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL to_gap_bus: got %b want 1100",
                     {SD_CSn, SD_MOSI, eng_abort, wr_done});
        end
        wr_eng_csn = 1;
    endtask

    task automatic test_final_cycle_err();
        bit seen, is_wr, err, abrt;
        int cyc;
        logic [1:0] e;
        do_reset();
        init_done = 1; rd_addr = 32'd5; rd_req = 1;
        wait_gnt(5, seen, is_wr, cyc);
        rd_req = 0;
        wait_start(3, seen, is_wr, cyc);
        repeat (TO - 1) @(negedge clk);
        rd_eng_done = 1; rd_eng_err = 1;
        exp_q.push_back(2'b01);
        wait_done(3, seen, is_wr, err, abrt, cyc);
        rd_eng_done = 0; rd_eng_err = 0;
        n_checks++;
        if ({seen, abrt, cyc} !== {1'b1, 1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL edge_abort: seen=%0b abort=%0b cyc=%0d want 1 0 1",
                     seen, abrt, cyc);
        end
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL edge_done: seen=%0b queued=%0d", seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({is_wr, err} !== e) begin
                n_fail++;
                $display("FAIL edge_done: got %b want %b", {is_wr, err}, e);
            end
        end
    endtask

    task automatic test_init_drop();
        bit seen, is_wr, err, abrt;
        int cyc;
        logic [1:0] e;
        do_reset();
        init_done = 1; wr_addr = 32'h77; wr_req = 1;
        wait_gnt(5, seen, is_wr, cyc);
        wr_req = 0;
        wait_start(3, seen, is_wr, cyc);
        wr_eng_csn = 0; wr_eng_mosi = 0;
        repeat (5) @(negedge clk);
        rd_addr = 32'h99; rd_req = 1;
        init_csn = 0; init_mosi = 1;
        exp_q.push_back(2'b11);
        init_done = 0;
        wait_done(3, seen, is_wr, err, abrt, cyc);
        n_checks++;
        if ({seen, abrt, cyc} !== {1'b1, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL drop_abort: seen=%0b abort=%0b cyc=%0d want 1 1 1",
                     seen, abrt, cyc);
        end
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL drop_done: seen=%0b queued=%0d", seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({is_wr, err} !== e) begin
                n_fail++;
                $display("FAIL drop_done: got %b want %b", {is_wr, err}, e);
            end
        end
        #1;
        n_checks++;
        if ({SD_CSn, SD_MOSI} !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_bus: got %b want 01", {SD_CSn, SD_MOSI});
        end
        wait_gnt(10, seen, is_wr, cyc);
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL drop_no_gnt: got gnt at %0d want none", cyc);
        end
        wr_eng_csn = 1; wr_eng_mosi = 1; init_csn = 1;
        init_done = 1;
        wait_gnt(5, seen, is_wr, cyc);
        n_checks++;
        if ({seen, is_wr} !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_regnt: seen=%0b wr=%0b want 1 0", seen, is_wr);
        end
        rd_req = 0;
        wait_start(3, seen, is_wr, cyc);
        n_checks++;
        if (blk_addr !== 32'h99) begin
            n_fail++;
            $display("FAIL drop_blk_addr: got %h want 99", blk_addr);
        end
        exp_q.push_back(2'b00);
        rd_eng_done = 1;
        wait_done(5, seen, is_wr, err, abrt, cyc);
        rd_eng_done = 0;
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL drop_rd_done: seen=%0b queued=%0d",
                     seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({is_wr, err} !== e) begin
                n_fail++;
                $display("FAIL drop_rd_done: got %b want %b", {is_wr, err}, e);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen, is_wr, err, abrt;
        int cyc;
        logic [1:0] e;
        do_reset();
        init_done = 1; rd_addr = 32'h33; rd_req = 1;
        wait_gnt(5, seen, is_wr, cyc);
        rd_req = 0;
        wait_start(3, seen, is_wr, cyc);
        rd_eng_csn = 0; rd_eng_mosi = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        n_checks++;
        if ({SD_CSn, SD_MOSI} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_bus: got %b want 11", {SD_CSn, SD_MOSI});
        end
        rd_eng_done = 1;
        wait_done(4, seen, is_wr, err, abrt, cyc);
        rd_eng_done = 0;
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_no_done: got done at %0d want none", cyc);
        end
        init_done = 0; rd_eng_csn = 1; rd_eng_mosi = 1;
        rd_req = 1; wr_req = 1; wr_addr = 32'h44;
        rst_n = 1;
        wait_gnt(4, seen, is_wr, cyc);
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_init_hold: got gnt at %0d want none", cyc);
        end
        init_done = 1;
        wait_gnt(5, seen, is_wr, cyc);
        n_checks++;
        if ({seen, is_wr} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_first_tie: seen=%0b wr=%0b want 1 0",
                     seen, is_wr);
        end
        rd_req = 0; wr_req = 0;
        wait_start(3, seen, is_wr, cyc);
        exp_q.push_back(2'b00);
        rd_eng_done = 1;
        wait_done(5, seen, is_wr, err, abrt, cyc);
        rd_eng_done = 0;
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rst_rd_done: seen=%0b queued=%0d",
                     seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({is_wr, err} !== e) begin
                n_fail++;
                $display("FAIL rst_rd_done: got %b want %b", {is_wr, err}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_round_robin();
        test_timeout();
        test_final_cycle_err();
        test_init_drop();
        test_reset_mid_busy();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
